// File: rtl/routing_crossbar_seq_pkg.sv
// Shared definitions for the lane routing crossbar: select-mode encodings.
package router_pkg;

    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_SCAN   = 2'b01;
    localparam logic [1:0] MODE_ROTATE = 2'b10;
    localparam logic [1:0] MODE_FREEZE = 2'b11;

endpackage

// File: rtl/routing_crossbar_seq_if.sv
// Lane bus between the switch/button inputs and the crossbar: source lanes, selects,
// mode control and the registered destination lanes with their status.
interface routing_crossbar_seq_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 4
);
    localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;

    logic [N*W-1:0] din;
    logic [SW-1:0]  src_sel;
    logic [SW-1:0]  dst_sel;
    logic           en;
    logic [1:0]     mode;
    logic [N*W-1:0] dout;
    logic [SW-1:0]  active_src;
    logic [SW-1:0]  active_dst;
    logic           tick;

    modport master (
        output din, src_sel, dst_sel, en, mode,
        input  dout, active_src, active_dst, tick
    );

    modport slave (
        input  din, src_sel, dst_sel, en, mode,
        output dout, active_src, active_dst, tick
    );
endinterface

// File: rtl/routing_crossbar_seq_prescaler.sv
// Free-running scan prescaler: counts 0..DIV-1 and flags the last count with a registered tick.
module prescaler #(
    parameter int unsigned DIV = 100000000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int unsigned CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          r_tick;

    assign w_cnt_next = (r_cnt == LAST) ? '0 : r_cnt + CW'(1);

    // tick mirrors "count == DIV-1" so it is computed from the next count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_tick <= (w_cnt_next == LAST);
        end
    end

    assign tick = r_tick;
endmodule

// File: rtl/routing_crossbar_seq.sv
// Registered N-lane crossbar: routes one source lane to one destination lane, with
// manual, scanning, rotating and frozen select modes.
module routing_crossbar_seq
    import router_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned W    = 4,
    parameter int unsigned DIV  = 100000000,
    parameter int unsigned HOLD = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    routing_crossbar_seq_if.slave bus
);
    localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;

    logic          w_tick;
    logic [SW-1:0] r_scan;
    logic [SW-1:0] r_src;
    logic [SW-1:0] r_dst;
    logic [SW-1:0] w_scan_next;
    logic [W-1:0]  w_din [N];
    logic [W-1:0]  r_lane [N];
    logic [W-1:0]  w_src_lane;

    prescaler #(.DIV(DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    assign w_scan_next = r_scan + SW'(1);

    // Select state; SCAN and ROTATE share one scan index so mode switches never jump
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan <= '0;
            r_src  <= '0;
            r_dst  <= '0;
        end else begin
            case (bus.mode)
                MODE_MANUAL: begin
                    r_src <= bus.src_sel;
                    r_dst <= bus.dst_sel;
                end
                MODE_SCAN: begin
                    if (w_tick) begin
                        r_scan <= w_scan_next;
                        r_src  <= w_scan_next;
                        r_dst  <= w_scan_next;
                    end
                end
                MODE_ROTATE: begin
                    if (w_tick) begin
                        r_scan <= w_scan_next;
                        r_src  <= w_scan_next;
                        r_dst  <= w_scan_next + SW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_src_lane = w_din[r_src];

    // Lane registers route from the currently applied select, giving the two-cycle select latency
    for (genvar i = 0; i < N; i++) begin : g_lane
        assign w_din[i] = bus.din[i*W +: W];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_lane[i] <= '0;
            end else if (bus.mode != MODE_FREEZE) begin
                if (bus.en && (r_dst == SW'(i))) begin
                    r_lane[i] <= w_src_lane;
                end else if (HOLD == 0) begin
                    r_lane[i] <= '0;
                end
            end
        end

        assign bus.dout[i*W +: W] = r_lane[i];
    end

    assign bus.active_src = r_src;
    assign bus.active_dst = r_dst;
    assign bus.tick       = w_tick;
endmodule

// File: tb/tb_routing_crossbar_seq.sv
// Self-checking bench for routing_crossbar_seq: HOLD=0 and HOLD=1 instances on shared
// stimulus, a cycle model feeding a scoreboard queue, plus directed lane-pattern checks.
module tb_routing_crossbar_seq;
    localparam int unsigned N   = 4;
    localparam int unsigned W   = 4;
    localparam int unsigned DIV = 4;

    typedef struct packed {
        logic [15:0] d0;
        logic [15:0] d1;
        logic [1:0]  src;
        logic [1:0]  dst;
        logic        tick;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] t_din;
    logic [1:0]  t_src;
    logic [1:0]  t_dst;
    logic        t_en;
    logic [1:0]  t_mode;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb_q[$];

    // reference state
    int          m_cnt;
    logic [1:0]  m_scan;
    logic [1:0]  m_src;
    logic [1:0]  m_dst;
    logic [15:0] m_d0;
    logic [15:0] m_d1;

    routing_crossbar_seq_if #(.N(N), .W(W)) if0 ();
    routing_crossbar_seq_if #(.N(N), .W(W)) if1 ();

    assign if0.din = t_din;  assign if1.din = t_din;
    assign if0.src_sel = t_src;  assign if1.src_sel = t_src;
    assign if0.dst_sel = t_dst;  assign if1.dst_sel = t_dst;
    assign if0.en = t_en;  assign if1.en = t_en;
    assign if0.mode = t_mode;  assign if1.mode = t_mode;

    routing_crossbar_seq #(.N(N), .W(W), .DIV(DIV), .HOLD(0)) u_dut0 (
        .clk (clk), .rst (rst), .bus (if0)
    );
    routing_crossbar_seq #(.N(N), .W(W), .DIV(DIV), .HOLD(1)) u_dut1 (
        .clk (clk), .rst (rst), .bus (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_scan = 2'd0;
        m_src  = 2'd0;
        m_dst  = 2'd0;
        m_d0   = 16'h0;
        m_d1   = 16'h0;
        sb_q.delete();
    endtask

    // Advance the model by one clock with the inputs currently driven; push the expectation
    task automatic model_step();
        logic        tk;
        logic [1:0]  sn;
        logic [3:0]  srcl;
        logic [15:0] nd0;
        logic [15:0] nd1;
        exp_t        e;
        tk   = (m_cnt == DIV - 1);
        nd0  = m_d0;
        nd1  = m_d1;
        srcl = t_din[m_src*4 +: 4];
        if (t_mode != 2'b11) begin
            for (int l = 0; l < 4; l++) begin
                if (t_en && (m_dst == 2'(l))) begin
                    nd0[l*4 +: 4] = srcl;
                    nd1[l*4 +: 4] = srcl;
                end else begin
                    nd0[l*4 +: 4] = 4'h0;
                end
            end
        end
        sn = m_scan + 2'd1;
        case (t_mode)
            2'b00: begin m_src = t_src; m_dst = t_dst; end
            2'b01: if (tk) begin m_scan = sn; m_src = sn; m_dst = sn; end
            2'b10: if (tk) begin m_scan = sn; m_src = sn; m_dst = sn + 2'd1; end
            default: ;
        endcase
        m_cnt  = tk ? 0 : m_cnt + 1;
        m_d0   = nd0;
        m_d1   = nd1;
        e.d0   = m_d0;
        e.d1   = m_d1;
        e.src  = m_src;
        e.dst  = m_dst;
        e.tick = (m_cnt == DIV - 1);
        sb_q.push_back(e);
    endtask

    task automatic cycle(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            model_step();
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                chk("sb_empty", 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                chk("dout_h0", 32'(if0.dout), 32'(e.d0));
                chk("dout_h1", 32'(if1.dout), 32'(e.d1));
                chk("active_src", 32'(if0.active_src), 32'(e.src));
                chk("active_dst", 32'(if0.active_dst), 32'(e.dst));
                chk("tick", 32'(if0.tick), 32'(e.tick));
            end
        end
    endtask

    // Called just after a rising edge; releases reset well before the next one
    task automatic do_reset();
        rst = 1'b1;
        #2;
        model_reset();
        rst = 1'b0;
    endtask

    task automatic drive(input logic [1:0] mode, input logic en, input logic [15:0] din,
                         input logic [1:0] src, input logic [1:0] dst);
        t_mode = mode;
        t_en   = en;
        t_din  = din;
        t_src  = src;
        t_dst  = dst;
    endtask

    initial begin
        rst = 1'b1;
        drive(2'b00, 1'b0, 16'h0, 2'd0, 2'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // SCAN loopback walks the lanes one tick at a time
        do_reset();
        drive(2'b01, 1'b1, 16'h4321, 2'd0, 2'd0);
        cycle(1); chk("scan_0", 32'(if0.dout), 32'h0001);
        cycle(4); chk("scan_1", 32'(if0.dout), 32'h0020);
        cycle(4); chk("scan_2", 32'(if0.dout), 32'h0300);
        cycle(4); chk("scan_3", 32'(if0.dout), 32'h4000);
        cycle(4); chk("scan_wrap", 32'(if0.dout), 32'h0001);

        // Asynchronous reset with dout nonzero, then prescaler restart
        rst = 1'b1;
        #1;
        chk("rst_dout", 32'(if0.dout), 32'h0);
        chk("rst_dout_h1", 32'(if1.dout), 32'h0);
        chk("rst_src", 32'(if0.active_src), 32'h0);
        chk("rst_dst", 32'(if0.active_dst), 32'h0);
        chk("rst_tick", 32'(if0.tick), 32'h0);
        #1;
        model_reset();
        rst = 1'b0;
        chk("tick_rel0", 32'(if0.tick), 32'h0);
        cycle(1); chk("tick_rel1", 32'(if0.tick), 32'h0);
        cycle(1); chk("tick_rel2", 32'(if0.tick), 32'h0);
        cycle(1); chk("tick_rel3", 32'(if0.tick), 32'h1);

        // ROTATE: destination one ahead of the source, wrapping 3 -> 0
        do_reset();
        drive(2'b10, 1'b1, 16'h4321, 2'd0, 2'd0);
        cycle(1); chk("rot_0", 32'(if0.dout), 32'h0001);
        cycle(4); chk("rot_1", 32'(if0.dout), 32'h0200);
        cycle(4); chk("rot_2", 32'(if0.dout), 32'h3000);
        cycle(4); chk("rot_wrap", 32'(if0.dout), 32'h0004);
        cycle(4); chk("rot_3", 32'(if0.dout), 32'h0010);

        // FREEZE holds outputs and selects through din changes and ticks
        do_reset();
        drive(2'b01, 1'b1, 16'h4321, 2'd0, 2'd0);
        cycle(9); chk("frz_pre", 32'(if0.dout), 32'h0300);
        drive(2'b11, 1'b1, 16'hFFFF, 2'd1, 2'd3);
        cycle(8);
        chk("frz_dout", 32'(if0.dout), 32'h0300);
        chk("frz_src", 32'(if0.active_src), 32'd2);
        chk("frz_dst", 32'(if0.active_dst), 32'd2);

        // MANUAL route: capture then route; HOLD instance keeps lane 1 after en drops
        do_reset();
        drive(2'b00, 1'b1, 16'hDCBA, 2'd2, 2'd1);
        cycle(1);
        cycle(1); chk("man_route", 32'(if0.dout), 32'h00C0);
        t_en = 1'b0;
        cycle(1);
        chk("man_off_h0", 32'(if0.dout), 32'h0);
        chk("man_hold_l1", 32'(if1.dout[7:4]), 32'hC);

        // MANUAL entered on the tick edge: no scan advance, select from buttons
        do_reset();
        drive(2'b01, 1'b1, 16'h4321, 2'd0, 2'd0);
        cycle(3); chk("mt_tick", 32'(if0.tick), 32'h1);
        drive(2'b00, 1'b1, 16'h4321, 2'd3, 2'd2);
        cycle(1);
        chk("mt_src", 32'(if0.active_src), 32'd3);
        chk("mt_dst", 32'(if0.active_dst), 32'd2);
        t_mode = 2'b01;
        cycle(1); chk("mt_route", 32'(if0.dout), 32'h0400);
        cycle(3); chk("mt_scan_src", 32'(if0.active_src), 32'd1);
        cycle(1); chk("mt_scan_dout", 32'(if0.dout), 32'h0020);

        // Random mix against the model
        for (int r = 0; r < 60; r++) begin
            drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 16'($urandom()),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            cycle(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
